// File: rtl/strobe_generator.sv
// strobe_generator: multi-channel programmable single-cycle strobe source with
// per-channel period/phase, periodic or one-shot mode, and a shared resync.
`default_nettype none

module strobe_generator #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS*WIDTH-1:0] period_m1,
    input  logic [CHANNELS*WIDTH-1:0] phase,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS-1:0]       active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t             state_q, state_d;
        logic [WIDTH-1:0]   cnt_q, cnt_d;
        logic               pulse_q, pulse_d;
        logic [WIDTH-1:0]   ch_period;
        logic [WIDTH-1:0]   ch_phase;

        assign ch_period = period_m1[i*WIDTH +: WIDTH];
        assign ch_phase  = phase[i*WIDTH +: WIDTH];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        // Disable beats sync, sync beats a due pulse; reload at zero means no underflow.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            if (!enable[i]) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (sync || state_q == IDLE) begin
                state_d = COUNT;
                cnt_d   = ch_phase;
            end else begin
                case (state_q)
                    COUNT: begin
                        if (cnt_q == '0) begin
                            pulse_d = 1'b1;
                            cnt_d   = ch_period;
                            state_d = oneshot[i] ? DONE : COUNT;
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                    DONE:    state_d = DONE;
                    default: state_d = IDLE;
                endcase
            end
        end

        assign pulse[i]  = pulse_q;
        assign active[i] = (state_q == COUNT);
    end

endmodule

`default_nettype wire

// File: tb/tb_strobe_generator.sv
// Scoreboarded directed bench for strobe_generator: stimulus queues expected
// pulse/active vectors per cycle, a monitor pops and compares them.
`default_nettype none

module tb_strobe_generator;

    localparam int CH = 4;
    localparam int W  = 16;

    logic              clk;
    logic              reset_n;
    logic [CH-1:0]     enable;
    logic [CH-1:0]     oneshot;
    logic [CH*W-1:0]   period_m1;
    logic [CH*W-1:0]   phase;
    logic              sync;
    logic [CH-1:0]     pulse;
    logic [CH-1:0]     active;

    strobe_generator #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .oneshot   (oneshot),
        .period_m1 (period_m1),
        .phase     (phase),
        .sync      (sync),
        .pulse     (pulse),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [3:0]  p;
        logic [3:0]  a;
        string       tag;
    } exp_t;

    exp_t q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int c, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, c, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] a, input string tag);
        exp_t e;
        e.c = c; e.p = p; e.a = a; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: outputs sampled on the falling edge, compared against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].c < cyc) begin
                e = q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL %s missed expectation cyc=%0d now=%0d", e.tag, e.c, cyc);
            end
            if (q.size() > 0 && q[0].c == cyc) begin
                e = q.pop_front();
                check({e.tag, ".pulse"},  cyc, pulse,  e.p);
                check({e.tag, ".active"}, cyc, active, e.a);
            end
        end
    end

    initial begin
        int b;
        reset_n   = 1'b0;
        enable    = '0;
        oneshot   = '0;
        period_m1 = '0;
        phase     = '0;
        sync      = 1'b0;
        push(1, 4'h0, 4'h0, "reset");
        push(2, 4'h0, 4'h0, "reset");

        // Reset held with all channels enabled, then release
        tick(2);
        b = cyc;
        for (int i = 0; i < CH; i++) begin
            period_m1[i*W +: W] = 16'd3;
            phase[i*W +: W]     = 16'd0;
        end
        enable = 4'hF;
        for (int c = b + 1; c <= b + 2; c++) push(c, 4'h0, 4'h0, "reset_hold");
        tick(3);
        reset_n = 1'b1;
        for (int c = b + 3; c <= b + 14; c++)
            push(c, (c >= b + 5 && (c - b - 5) % 4 == 0) ? 4'hF : 4'h0,
                    (c >= b + 4) ? 4'hF : 4'h0, "release");
        tick(11);
        enable = '0;
        push(b + 15, 4'h0, 4'h0, "release_off");
        tick(2);

        // Divide-by-one
        b = cyc;
        period_m1[0 +: W] = 16'd0;
        phase[0 +: W]     = 16'd0;
        enable = 4'b0001;
        for (int c = b; c <= b + 7; c++)
            push(c, (c >= b + 2) ? 4'b0001 : 4'b0000, (c >= b + 1) ? 4'b0001 : 4'b0000, "div1");
        tick(7);
        enable = '0;
        push(b + 8, 4'h0, 4'h0, "div1_off");
        tick(2);

        // Phase alignment; sync lands on ch1's due edge and cancels it
        b = cyc;
        period_m1[0 +: W] = 16'd4; phase[0 +: W] = 16'd0;
        period_m1[W +: W] = 16'd4; phase[W +: W] = 16'd2;
        enable = 4'b0011;
        for (int c = b; c <= b + 22; c++) begin
            int k;
            logic [3:0] p;
            k = c - b;
            p = 4'b0000;
            p[0] = (k == 2) || (k == 7) || (k >= 10 && (k - 10) % 5 == 0);
            p[1] = (k == 4) || (k >= 12 && (k - 12) % 5 == 0);
            push(c, p, (k >= 1) ? 4'b0011 : 4'b0000, "align");
        end
        tick(8);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        tick(13);
        enable = '0;
        push(b + 23, 4'h0, 4'h0, "align_off");
        tick(2);

        // One-shot on ch2, re-armed by sync
        b = cyc;
        period_m1[2*W +: W] = 16'd7; phase[2*W +: W] = 16'd5;
        oneshot = 4'b0100;
        enable  = 4'b0100;
        for (int c = b; c <= b + 24; c++) begin
            int k;
            k = c - b;
            push(c, (k == 7 || k == 19) ? 4'b0100 : 4'b0000,
                    ((k >= 1 && k <= 6) || (k >= 13 && k <= 18)) ? 4'b0100 : 4'b0000, "oneshot");
        end
        tick(12);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        tick(11);
        enable  = '0;
        oneshot = '0;
        push(b + 25, 4'h0, 4'h0, "oneshot_off");
        tick(2);

        // Live reprogram 9 -> 2 mid-interval on ch3
        b = cyc;
        period_m1[3*W +: W] = 16'd9; phase[3*W +: W] = 16'd0;
        enable = 4'b1000;
        for (int c = b; c <= b + 22; c++) begin
            int k;
            k = c - b;
            push(c, (k == 2 || (k >= 12 && (k - 12) % 3 == 0)) ? 4'b1000 : 4'b0000,
                    (k >= 1) ? 4'b1000 : 4'b0000, "reprog");
        end
        tick(5);
        period_m1[3*W +: W] = 16'd2;
        tick(17);
        enable = '0;
        push(b + 23, 4'h0, 4'h0, "reprog_off");
        tick(2);

        // Collisions: disable on a due edge, then async reset mid-pulse
        b = cyc;
        period_m1[0 +: W] = 16'd3; phase[0 +: W] = 16'd0;
        enable = 4'b0001;
        for (int c = b; c <= b + 11; c++) begin
            int k;
            k = c - b;
            push(c, (k == 2 || k == 6) ? 4'b0001 : 4'b0000,
                    (k >= 1 && k <= 9) ? 4'b0001 : 4'b0000, "dis_due");
        end
        tick(9);
        enable = '0;
        tick(3);
        enable = 4'b0001;
        push(b + 12, 4'b0000, 4'b0000, "rearm");
        push(b + 13, 4'b0000, 4'b0001, "rearm");
        tick(2);
        check("pre_reset.pulse", cyc, pulse, 4'b0001);
        for (int c = b + 14; c <= b + 16; c++) push(c, 4'h0, 4'h0, "mid_reset");
        reset_n = 1'b0;
        #1;
        check("async_reset.pulse",  cyc, pulse,  4'b0000);
        check("async_reset.active", cyc, active, 4'b0000);
        tick(2);
        reset_n = 1'b1;
        push(b + 17, 4'b0000, 4'b0001, "post_reset");
        push(b + 18, 4'b0001, 4'b0001, "post_reset");
        tick(2);
        enable = '0;
        push(b + 19, 4'h0, 4'h0, "post_reset_off");
        tick(1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
